moore_seq_detect_param: RTL
===========================

Name: moore_seq_detect_param

Overview:
Parametrised Moore-style serial sequence detector. It is the generalised successor to the fixed 4-bit 1010 overlapping detector.
- Pattern length is set at elaboration; the pattern itself is loadable at runtime.
- Overlapping or non-overlapping detection is selectable per cycle.
- Serial bits are qualified by a valid strobe, and a saturating match counter is provided.
- Sits on a serial bit stream, e.g. behind a deserialiser or line decoder, and feeds framing or status logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..32).
- DEF_PAT, 4'b1010 (PAT_W bits), pattern value after reset.
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data bit.
- bit_vld  in  1  bit_in is sampled only when high.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled with each valid bit.
- pat_load  in  1  load strobe for pat_in.
- pat_in  in  PAT_W  new pattern; first-received bit is the MSB.
- detect  out  1  registered match flag.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- One clock, clk. reset is synchronous and active-high. All state updates on rising clk.
- Internal state:
  - pat_r[PAT_W-1:0]: active pattern.
  - hist[PAT_W-1:0]: last received bits, newest at LSB.
  - fill: 0..PAT_W, valid bits in hist.
- Reset values: pat_r=DEF_PAT, hist=0, fill=0, detect=0, match_cnt=0.
- Priority per cycle: reset > pat_load > bit_vld.
- pat_load=1 (no reset):
  - pat_r<=pat_in; hist<=0; fill<=0; detect<=0; match_cnt<=0.
  - A coincident bit_vld bit is discarded.
- bit_vld=1 (no reset, no load):
  - nh={hist[PAT_W-2:0],bit_in}; nf=min(fill+1,PAT_W).
  - hit=(nf==PAT_W)&&(nh==pat_r).
  - hist<=nh; detect<=hit.
  - If hit and match_cnt != all-ones, match_cnt increments; if already all-ones it holds.
  - Non-overlap (overlap=0) with hit: fill<=0, so the next match needs PAT_W fresh bits.
  - Otherwise fill<=nf.
- bit_vld=0 (no reset, no load): detect<=0; all other state holds.
- Detect timing:
  - detect is a pure register (Moore); there is no combinational path from inputs to outputs.
  - detect is high for exactly one clk cycle, the cycle after the edge that sampled the completing bit.
  - Back-to-back overlapped matches give detect high on consecutive valid-bit cycles.
- Switching overlap mid-stream takes effect on the next valid bit. History is not cleared.
- A reset mid-stream discards partial matches. The first detection after reset needs PAT_W valid bits.
- Pattern all-zeros and all-ones are legal. An all-ones pattern in overlap mode on constant 1s detects every valid cycle once fill==PAT_W.

Decomposition:
- Shared package moore_seq_pkg:
  - Default pattern constant.
  - Mode encoding constants MODE_NOVL=0, MODE_OVL=1.
  - A function sat_inc(cnt) returning cnt+1, saturating at all-ones.
- One natural sub-module: sat_counter (CNT_W-wide; inc, clr, sync active-high reset), instantiated for match_cnt.
- Shift/compare logic stays in the top module.

Test Plan:
- Overlap, default pattern 1010:
  - Stimulus: reset, then overlap=1, bit_vld=1 continuously, bits 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0.
  - Required: detect pulses after bits 4, 6, 12, 14 (0-based); match_cnt=4.
- Non-overlap, same stream, overlap=0:
  - Required: detect after bits 4 and 12 only; match_cnt=2.
- Valid gaps:
  - Stimulus: bits 1,0,1,0 with bit_vld low for 3 cycles between each bit.
  - Required: exactly one detect pulse, one cycle after the final valid bit; detect=0 during gaps.
- Runtime pattern load, PAT_W=4:
  - Stimulus: pat_load=1 with pat_in=4'b0110, coincident with bit_vld=1; then stream 0,1,1,0,1,1,0 with overlap=1.
  - Required: the coincident bit is ignored; match_cnt cleared to 0; detect after bits 3 and 6; match_cnt=2.
- Saturation and reset:
  - Stimulus: CNT_W=2, pattern 1111, overlap=1, 10 consecutive 1s.
  - Required: 7 detect pulses; match_cnt sticks at 3.
  - Then assert reset mid-stream: next cycle detect=0, match_cnt=0, pat_r back to 1010.
- Partial-match abort:
  - Stimulus: bits 1,0,1, reset for 1 cycle, then 0.
  - Required: no detect.
  - Then 1,0,1,0: detect after the 4th post-reset bit.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared definitions for the parametrised Moore sequence detector.
//   DEF_PAT_VAL : pattern loaded at reset for the default 4-bit build (1010)
//   MODE_NOVL / MODE_OVL : encoding of the overlap input
//   sat_inc()   : increment that sticks at a caller-supplied maximum
package moore_seq_pkg;

  localparam logic [3:0] DEF_PAT_VAL = 4'b1010;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  // Widest counter the helper supports; callers zero-extend into this width.
  localparam int SAT_MAX_W = 32;

  // Returns cnt+1, or cnt unchanged once it has reached max_val (all-ones of
  // the caller's real width, zero-extended).
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                   input logic [SAT_MAX_W-1:0] max_val);
    logic [SAT_MAX_W-1:0] res;
    if (cnt >= max_val) begin
      res = cnt;
    end else begin
      res = cnt + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/moore_seq_detect_param_sat_counter.sv
// Saturating up-counter used for the match count.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (clears count)
//   clr   : synchronous clear, lower priority than reset
//   inc   : increment request, ignored once the count is all-ones
//   cnt   : registered count value
module sat_counter
  import moore_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [SAT_MAX_W-1:0] MAX_VAL = SAT_MAX_W'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0]     cnt_r;
  logic [SAT_MAX_W-1:0] inc_full_s;
  logic [CNT_W-1:0]     cnt_inc_s;
  logic                 unused_inc_s;

  // Saturating next value, computed at full helper width then narrowed.
  always_comb begin
    inc_full_s = sat_inc(SAT_MAX_W'(cnt_r), MAX_VAL);
    cnt_inc_s  = inc_full_s[CNT_W-1:0];
  end

  // Upper helper bits are always zero for CNT_W < 32; fold them away.
  assign unused_inc_s = ^inc_full_s;

  // Count register: reset > clr > inc.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_inc_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/moore_seq_detect_param.sv
// Parametrised Moore serial sequence detector with runtime-loadable pattern,
// selectable overlapping / non-overlapping detection and a saturating
// match counter.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   bit_in    : serial data bit, sampled when bit_vld is high
//   bit_vld   : qualifies bit_in
//   overlap   : 1 = overlapping, 0 = non-overlapping (per valid bit)
//   pat_load  : loads pat_in, clears history and count
//   pat_in    : new pattern, MSB is the first bit received
//   detect    : registered one-cycle match pulse
//   match_cnt : saturating number of matches since reset / load
module moore_seq_detect_param
  import moore_seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_VAL),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt
);

  // fill counts 0..PAT_W inclusive.
  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic              detect_r;

  logic [PAT_W-1:0]  nh_s;
  logic [FILL_W-1:0] nf_s;
  logic              hit_s;
  logic              cnt_inc_s;

  // Candidate history/fill after accepting bit_in, and the match decision.
  // A match needs a full window of bits received since the last clear.
  always_comb begin
    nh_s = {hist_r[PAT_W-2:0], bit_in};
    if (fill_r == FILL_FULL) begin
      nf_s = fill_r;
    end else begin
      nf_s = fill_r + FILL_W'(1);
    end
    hit_s = (nf_s == FILL_FULL) && (nh_s == pat_r);
  end

  // Count only on an accepted valid bit; a load clears the count instead.
  assign cnt_inc_s = bit_vld & ~pat_load & hit_s;

  // Pattern, history, fill and detect registers: reset > pat_load > bit_vld.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r    <= DEF_PAT;
      hist_r   <= {PAT_W{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
      detect_r <= 1'b0;
    end else if (pat_load) begin
      // Any coincident valid bit is dropped.
      pat_r    <= pat_in;
      hist_r   <= {PAT_W{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
      detect_r <= 1'b0;
    end else if (bit_vld) begin
      pat_r    <= pat_r;
      hist_r   <= nh_s;
      detect_r <= hit_s;
      // Non-overlapping: restart the window so the next match uses fresh bits.
      // hist is left alone; fill alone gates the next comparison.
      if (hit_s && (overlap == MODE_NOVL)) begin
        fill_r <= {FILL_W{1'b0}};
      end else begin
        fill_r <= nf_s;
      end
    end else begin
      pat_r    <= pat_r;
      hist_r   <= hist_r;
      fill_r   <= fill_r;
      detect_r <= 1'b0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (pat_load),
    .inc   (cnt_inc_s),
    .cnt   (match_cnt)
  );

  assign detect = detect_r;

endmodule
